uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: NREQ, 4, number of requesters (2..8).
REQ-002 Parameter: DW, 8, byte width.
REQ-003 Parameter: BUSY_TMO, 16, max cycles from tx_start to tx_busy rising.
REQ-004 Port: clk  input  1  single clock; all logic on rising edge.
REQ-005 Port: rst_n  input  1  synchronous, active-high reset (1 = reset).
REQ-006 Port: req  input  NREQ  per-requester byte-send request, level.
REQ-007 Port: req_data  input  NREQ*DW  requester i byte at [i*DW +: DW].
REQ-008 Port: req_lock  input  NREQ  per-requester hold-grant hint, used only when UART_ARB_LOCK_EN is defined.
REQ-009 Port: grant  output  NREQ  one-hot current owner, zero when idle.
REQ-010 Port: ack  output  NREQ  one-cycle pulse to owner on byte completion.
REQ-011 Port: err  output  1  one-cycle pulse on transmitter timeout.
REQ-012 Port: tx_start  output  1  one-cycle start pulse to byte transmitter.
REQ-013 Port: tx_data  output  DW  byte to transmitter, registered, stable from START to DONE.
REQ-014 Port: tx_busy  input  1  transmitter busy, high during start/data/stop bits.
REQ-015 Port: busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE, DONE.
REQ-017 IDLE: if any req bit set, grant the first set bit searching from ptr upward with wrap at NREQ-1 to 0, latch req_data of the winner into tx_data, and go to START the next cycle.
REQ-018 START: tx_start=1 for exactly one cycle; go to WAIT_BUSY.
REQ-019 WAIT_BUSY: go to WAIT_DONE on tx_busy=1; after BUSY_TMO cycles without tx_busy, pulse err, clear grant, set ptr to owner+1 mod NREQ, go to IDLE, no ack.
REQ-020 WAIT_DONE: go to DONE on tx_busy=0.
REQ-021 DONE: ack[owner]=1 for one cycle; set ptr to owner+1 mod NREQ; clear grant; go to IDLE.
REQ-022 Latency: req rises in IDLE at cycle n -> grant at n+1 -> tx_start at n+1 -> earliest next grant at the cycle after DONE.
REQ-023 If the owner drops req mid-transfer, the transfer completes and ack still pulses; req_data changes after the grant cycle are ignored.
REQ-024 Requests arriving on the same cycle as DONE are evaluated in the following IDLE cycle with the updated ptr.
REQ-025 grant is one-hot or zero in every cycle; ack and err are never asserted together.
REQ-026 tx_busy high in IDLE or START is ignored.

Reset
REQ-027 While rst_n=1 at a clk edge: state=IDLE, ptr=0, grant=0, ack=0, err=0, tx_start=0, tx_data=0, busy=0.
REQ-028 Reset mid-transfer aborts immediately; no ack or err is generated.

Configuration
REQ-029 Macro UART_ARB_LOCK_EN defined: in DONE, if req[owner]=1 and req_lock[owner]=1, keep grant, leave ptr unchanged, latch the new req_data[owner], and go to START; ack still pulses in DONE.
REQ-030 Macro UART_ARB_LOCK_EN undefined: req_lock is ignored and every grant releases in DONE per REQ-021.

Verification
REQ-031 Reset: rst_n=1 with req=4'b1111 -> all outputs 0; after release, first grant=4'b0001 with tx_data=req_data[7:0].
REQ-032 Round robin: req=4'b1111 held, model tx_busy 3 cycles high per byte -> grant sequence 0001,0010,0100,1000,0001 with one ack per grant.
REQ-033 Timeout: tx_busy held 0 after tx_start -> err pulses exactly 17 cycles after tx_start, no ack, next grant goes to owner+1.
REQ-034 Drop/mutate: owner 2 deasserts req and changes req_data from 8'h41 to 8'h42 after grant -> tx_data stays 8'h41, ack[2] pulses.
REQ-035 Lock (macro defined): req=4'b0011 with req_lock[0]=1 for 3 bytes -> three consecutive grants to 0, then grant to 1; without the macro, grants alternate 0,1,0.
REQ-036 Mid-transfer reset: assert rst_n during WAIT_DONE -> next cycle IDLE, grant=0, no ack or err, and ptr=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one byte transmitter.
// Optional UART_ARB_LOCK_EN lets the owner keep the grant for back-to-back bytes.
module uart_tx_arbiter #(
    parameter int NREQ     = 4,
    parameter int DW       = 8,
    parameter int BUSY_TMO = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]    req_lock,
    output logic [NREQ-1:0]    grant,
    output logic [NREQ-1:0]    ack,
    output logic               err,
    output logic               tx_start,
    output logic [DW-1:0]      tx_data,
    input  logic               tx_busy,
    output logic               busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(BUSY_TMO + 1);

    typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, DONE} state_t;

    state_t          state, state_nx;
    logic [PW-1:0]   ptr, ptr_nx, own, own_nx, own_inc, win, idx;
    logic            win_vld;
    logic [NREQ-1:0] grant_nx;
    logic [DW-1:0]   data_nx;
    logic            err_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [DW-1:0]   rd [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_rd
        assign rd[i] = req_data[i*DW +: DW];
    end

`ifndef UART_ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^req_lock;
`endif

    // Descending scan so the last hit is the first set bit at or after ptr.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = PW'((int'(ptr) + i) % NREQ);
            if (req[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

    assign own_inc = (own == PW'(NREQ - 1)) ? '0 : own + 1'b1;

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        own_nx   = own;
        grant_nx = grant;
        data_nx  = tx_data;
        err_nx   = 1'b0;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    grant_nx = {{(NREQ-1){1'b0}}, 1'b1} << win;
                    own_nx   = win;
                    data_nx  = rd[win];
                    state_nx = START;
                end
            end
            START: begin
                cnt_nx   = '0;
                state_nx = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nx = WAIT_DONE;
                end else if (cnt == CW'(BUSY_TMO - 1)) begin
                    err_nx   = 1'b1;
                    grant_nx = '0;
                    ptr_nx   = own_inc;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) state_nx = DONE;
            end
            DONE: begin
`ifdef UART_ARB_LOCK_EN
                if (req[own] && req_lock[own]) begin
                    data_nx  = rd[own];
                    state_nx = START;
                end else begin
                    grant_nx = '0;
                    ptr_nx   = own_inc;
                    state_nx = IDLE;
                end
`else
                grant_nx = '0;
                ptr_nx   = own_inc;
                state_nx = IDLE;
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            own     <= '0;
            grant   <= '0;
            tx_data <= '0;
            err     <= 1'b0;
            cnt     <= '0;
        end else begin
            state   <= state_nx;
            ptr     <= ptr_nx;
            own     <= own_nx;
            grant   <= grant_nx;
            tx_data <= data_nx;
            err     <= err_nx;
            cnt     <= cnt_nx;
        end
    end

    // Handshake strobes decode straight from the state so they are exactly one cycle wide.
    assign ack      = (state == DONE) ? grant : '0;
    assign tx_start = (state == START);
    assign busy     = (state != IDLE);
endmodule
